// File: rtl/wash_cycle_ctrl_if.sv
// Front-panel / actuator bundle for the washing-machine program controller.
// master = panel and actuator side, slave = wash_cycle_ctrl.
interface wash_cycle_ctrl_if #(
    parameter int TW = 8
);
    logic          start;
    logic          pause;
    logic          abort;
    logic          door_closed;
    logic          water;
    logic          detergent;
    logic          motor;
    logic          door_lock;
    logic          busy;
    logic          done;
    logic [2:0]    phase;
    logic [2:0]    rinse_idx;
    logic [TW-1:0] min_left;

    modport master (
        output start, pause, abort, door_closed,
        input  water, detergent, motor, door_lock, busy, done, phase, rinse_idx, min_left
    );

    modport slave (
        input  start, pause, abort, door_closed,
        output water, detergent, motor, door_lock, busy, done, phase, rinse_idx, min_left
    );
endinterface

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine program controller: [SOAK,] WASH, RINSE x RINSE_CYCLES, SPIN, DONE.
// Define WASH_PRESOAK_EN to add the SOAK phase (SOAK_MIN ticks) ahead of WASH.
module wash_cycle_ctrl #(
    parameter int TICK_DIV     = 4,
    parameter int WASH_MIN     = 30,
    parameter int RINSE_MIN    = 30,
    parameter int SPIN_MIN     = 45,
    parameter int RINSE_CYCLES = 1,
    parameter int TW           = 8
`ifdef WASH_PRESOAK_EN
    , parameter int SOAK_MIN   = 15
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    wash_cycle_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WASH  = 3'd1;
    localparam logic [2:0] S_RINSE = 3'd2;
    localparam logic [2:0] S_SPIN  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef WASH_PRESOAK_EN
    localparam logic [2:0] S_SOAK  = 3'd5;
    localparam logic [2:0] S_FIRST = S_SOAK;
    localparam int         FIRST_MIN = SOAK_MIN;
`else
    localparam logic [2:0] S_FIRST = S_WASH;
    localparam int         FIRST_MIN = WASH_MIN;
`endif

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    logic [2:0]    state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [TW-1:0] min_left_reg, min_left_next;
    logic [2:0]    rinse_idx_reg, rinse_idx_next;
    logic          start_d_reg;

    logic busy, run_en, tick, expire, start_edge, more_rinses;
    logic water, detergent, motor;

    always_comb begin
        busy = (state_reg == S_WASH) || (state_reg == S_RINSE) || (state_reg == S_SPIN);
`ifdef WASH_PRESOAK_EN
        busy = busy || (state_reg == S_SOAK);
`endif
    end

    assign run_en      = busy & ~bus.pause & bus.door_closed;
    assign tick        = run_en && (presc_reg == PRESC_LAST);
    assign expire      = tick && (min_left_reg == TW'(1));
    assign start_edge  = bus.start & ~start_d_reg;
    assign more_rinses = ({1'b0, rinse_idx_reg} + 4'd1) < 4'(RINSE_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            presc_reg     <= '0;
            min_left_reg  <= '0;
            rinse_idx_reg <= '0;
            start_d_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            presc_reg     <= presc_next;
            min_left_reg  <= min_left_next;
            rinse_idx_reg <= rinse_idx_next;
            start_d_reg   <= bus.start;
        end
    end

    always_comb begin
        state_next     = state_reg;
        presc_next     = presc_reg;
        min_left_next  = min_left_reg;
        rinse_idx_next = rinse_idx_reg;

        // Prescaler and countdown freeze whenever run_en is low (pause or open door).
        if (run_en) begin
            presc_next = tick ? '0 : presc_reg + PW'(1);
        end
        if (tick) begin
            min_left_next = min_left_reg - TW'(1);
        end

        case (state_reg)
            S_IDLE: begin
                if (start_edge && bus.door_closed) begin
                    state_next     = S_FIRST;
                    min_left_next  = TW'(FIRST_MIN);
                    presc_next     = '0;
                    rinse_idx_next = '0;
                end
            end
`ifdef WASH_PRESOAK_EN
            S_SOAK: begin
                if (expire) begin
                    state_next    = S_WASH;
                    min_left_next = TW'(WASH_MIN);
                    presc_next    = '0;
                end
            end
`endif
            S_WASH: begin
                if (expire) begin
                    state_next     = S_RINSE;
                    min_left_next  = TW'(RINSE_MIN);
                    presc_next     = '0;
                    rinse_idx_next = '0;
                end
            end
            S_RINSE: begin
                if (expire) begin
                    presc_next = '0;
                    if (more_rinses) begin
                        rinse_idx_next = rinse_idx_reg + 3'd1;
                        min_left_next  = TW'(RINSE_MIN);
                    end else begin
                        state_next    = S_SPIN;
                        min_left_next = TW'(SPIN_MIN);
                    end
                end
            end
            S_SPIN: begin
                if (expire) begin
                    state_next    = S_DONE;
                    min_left_next = '0;
                    presc_next    = '0;
                end
            end
            S_DONE: begin
                state_next     = S_IDLE;
                min_left_next  = '0;
                presc_next     = '0;
                rinse_idx_next = '0;
            end
            default: begin
                state_next     = S_IDLE;
                min_left_next  = '0;
                presc_next     = '0;
                rinse_idx_next = '0;
            end
        endcase

        // Abort wins over any tick or expiry in the same cycle.
        if (busy && bus.abort) begin
            state_next     = S_IDLE;
            min_left_next  = '0;
            presc_next     = '0;
            rinse_idx_next = '0;
        end
    end

    always_comb begin
        water     = 1'b0;
        detergent = 1'b0;
        motor     = 1'b0;
        case (state_reg)
`ifdef WASH_PRESOAK_EN
            S_SOAK: begin
                water     = run_en;
                detergent = run_en;
            end
`endif
            S_WASH: begin
                water     = run_en;
                detergent = run_en;
                motor     = run_en;
            end
            S_RINSE: begin
                water = run_en;
                motor = run_en;
            end
            S_SPIN: begin
                motor = run_en;
            end
            default: begin
                water     = 1'b0;
                detergent = 1'b0;
                motor     = 1'b0;
            end
        endcase
    end

    assign bus.water     = water;
    assign bus.detergent = detergent;
    assign bus.motor     = motor;
    assign bus.door_lock = busy;
    assign bus.busy      = busy;
    assign bus.done      = (state_reg == S_DONE);
    assign bus.phase     = state_reg;
    assign bus.rinse_idx = rinse_idx_reg;
    assign bus.min_left  = min_left_reg;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Self-checking bench for wash_cycle_ctrl: program-schedule reference model plus directed scenarios
// and randomized panel activity. Honours WASH_PRESOAK_EN (SOAK_MIN=2).
module tb_wash_cycle_ctrl;

    localparam int TD = 2;
    localparam int WM = 3;
    localparam int RM = 2;
    localparam int SM = 2;
    localparam int RC = 2;
    localparam int TW = 8;
`ifdef WASH_PRESOAK_EN
    localparam int SOAK_M   = 2;
    localparam int SOAK_EXP = 4;
`else
    localparam int SOAK_EXP = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic abort = 1'b0;
    logic door  = 1'b1;

    wash_cycle_ctrl_if #(.TW(TW)) bus ();

    assign bus.start       = start;
    assign bus.pause       = pause;
    assign bus.abort       = abort;
    assign bus.door_closed = door;

    wash_cycle_ctrl #(
        .TICK_DIV     (TD),
        .WASH_MIN     (WM),
        .RINSE_MIN    (RM),
        .SPIN_MIN     (SM),
        .RINSE_CYCLES (RC),
        .TW           (TW)
`ifdef WASH_PRESOAK_EN
        , .SOAK_MIN   (SOAK_M)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the program is a list of segments; seg=-1 idle, seg=nseg is the DONE cycle,
    // rem counts run cycles left in the current segment.
    int seg_ph [16];
    int seg_ix [16];
    int seg_mn [16];
    int nseg = 0;

    typedef struct packed {
        int seg;
        int rem;
    } mstate_t;

    mstate_t ms;
    logic    m_sd;

    function automatic mstate_t model_next();
        mstate_t n;
        n = ms;
        if (n.seg == nseg) begin
            n.seg = -1;
            n.rem = 0;
        end else if (n.seg < 0) begin
            if (start && !m_sd && door) begin
                n.seg = 0;
                n.rem = seg_mn[0] * TD;
            end
        end else if (abort) begin
            n.seg = -1;
            n.rem = 0;
        end else if (!pause && door) begin
            n.rem = n.rem - 1;
            if (n.rem == 0) begin
                n.seg = n.seg + 1;
                if (n.seg < nseg) n.rem = seg_mn[n.seg] * TD;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms   <= '{seg: -1, rem: 0};
            m_sd <= 1'b0;
        end else begin
            ms   <= model_next();
            m_sd <= start;
        end
    end

    function automatic int exp_phase();
        if (ms.seg < 0) return 0;
        if (ms.seg == nseg) return 4;
        return seg_ph[ms.seg];
    endfunction

    function automatic logic [19:0] exp_vec();
        logic b, run, w, d, m;
        int ph, ri, ml;
        b   = (ms.seg >= 0) && (ms.seg < nseg);
        run = b && !pause && door;
        ph  = exp_phase();
        w   = run && (ph == 1 || ph == 2 || ph == 5);
        d   = run && (ph == 1 || ph == 5);
        m   = run && (ph == 1 || ph == 2 || ph == 3);
        ri  = b ? seg_ix[ms.seg] : ((ms.seg == nseg) ? RC - 1 : 0);
        ml  = b ? (ms.rem + TD - 1) / TD : 0;
        return {w, d, m, b, b, (ms.seg == nseg), 3'(ph), 3'(ri), 8'(ml)};
    endfunction

    function automatic logic [19:0] act_vec();
        return {bus.water, bus.detergent, bus.motor, bus.door_lock, bus.busy, bus.done,
                bus.phase, bus.rinse_idx, bus.min_left};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every bench cycle passes through here: compare all outputs against the model, then release inputs.
    task automatic step();
        @(negedge clk);
        if (rst_n) begin
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t got=%h expected=%h (w,d,m,lock,busy,done,ph,ri,ml)",
                         $time, act_vec(), exp_vec());
            end
        end
        #1;
    endtask

    task automatic full_run(input string tag);
        int wc, r0, r1, sc, dc, kc, nb;
        wc = 0; r0 = 0; r1 = 0; sc = 0; dc = 0; kc = 0; nb = 0;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (i == 0) start = 1'b0;
            if (bus.phase == 3'd5) kc++;
            if (bus.phase == 3'd1) wc++;
            if (bus.phase == 3'd2 && bus.rinse_idx == 3'd0) r0++;
            if (bus.phase == 3'd2 && bus.rinse_idx == 3'd1) r1++;
            if (bus.phase == 3'd3) sc++;
            if (bus.done) dc++;
            if ((bus.phase == 3'd1 || bus.phase == 3'd2 || bus.phase == 3'd3) && !bus.busy) nb++;
        end
        chk({tag, "_soak_cycles"}, kc, SOAK_EXP);
        chk({tag, "_wash_cycles"}, wc, 6);
        chk({tag, "_rinse0_cycles"}, r0, 4);
        chk({tag, "_rinse1_cycles"}, r1, 4);
        chk({tag, "_spin_cycles"}, sc, 4);
        chk({tag, "_done_pulses"}, dc, 1);
        chk({tag, "_busy_drop"}, nb, 0);
        chk({tag, "_end_idle"}, int'(bus.phase), 0);
    endtask

    initial begin
        int wc, sc, dc, found, pz;

`ifdef WASH_PRESOAK_EN
        seg_ph[nseg] = 5; seg_ix[nseg] = 0; seg_mn[nseg] = SOAK_M; nseg++;
`endif
        seg_ph[nseg] = 1; seg_ix[nseg] = 0; seg_mn[nseg] = WM; nseg++;
        for (int r = 0; r < RC; r++) begin
            seg_ph[nseg] = 2; seg_ix[nseg] = r; seg_mn[nseg] = RM; nseg++;
        end
        seg_ph[nseg] = 3; seg_ix[nseg] = RC - 1; seg_mn[nseg] = SM; nseg++;

        // Reset state
        #12;
        chk("reset_outputs", int'(act_vec()), 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        step();
        chk("post_reset_phase", int'(bus.phase), 0);
        chk("post_reset_min_left", int'(bus.min_left), 0);

        // Scenario 1: nominal program
        full_run("run1");

        // Scenario 2: 5-cycle pause mid-WASH
        wc = 0; pz = 0;
        start = 1'b1;
        for (int i = 0; i < 34; i++) begin
            step();
            if (i == 0) start = 1'b0;
            if (pause && bus.phase == 3'd1 && pz == 0) begin
                chk("pause_actuators", int'({bus.water, bus.detergent, bus.motor}), 0);
                chk("pause_lock", int'(bus.door_lock), 1);
                pz = 1;
            end
            if (bus.phase == 3'd1) wc++;
            pause = (wc >= 2 && wc < 7);
        end
        pause = 1'b0;
        chk("pause_wash_cycles", wc, 11);

        // Scenario 3: start with door open is ignored; door opened mid-SPIN extends it
        door = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("door_open_start_phase", int'(bus.phase), 0);
        chk("door_open_start_outputs", int'(act_vec()), 0);
        door = 1'b1;
        step();
        sc = 0; pz = 0;
        start = 1'b1;
        for (int i = 0; i < 34; i++) begin
            step();
            if (i == 0) start = 1'b0;
            if (!door && bus.phase == 3'd3 && pz == 0) begin
                chk("door_open_motor", int'(bus.motor), 0);
                chk("door_open_lock", int'(bus.door_lock), 1);
                pz = 1;
            end
            if (bus.phase == 3'd3) sc++;
            door = !(sc >= 1 && sc < 4);
        end
        door = 1'b1;
        chk("door_spin_cycles", sc, 7);

        // Scenario 4: abort on the same cycle as a RINSE expiry tick
        found = 0; dc = 0;
        start = 1'b1;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (i == 0) start = 1'b0;
            if (bus.done) dc++;
            if (exp_phase() == 2 && ms.rem == 1) found = 1;
        end
        chk("abort_reach_expiry", found, 1);
        chk("abort_pre_min_left", int'(bus.min_left), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_phase", int'(bus.phase), 0);
        chk("abort_outputs", int'(act_vec()), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.done) dc++;
        end
        chk("abort_no_done", dc, 0);

        // Scenario 5: asynchronous reset mid-SPIN, then a fresh full run
        found = 0;
        start = 1'b1;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (i == 0) start = 1'b0;
            if (bus.phase == 3'd3) found = 1;
        end
        chk("reach_spin", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(act_vec()), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("reset_release_phase", int'(bus.phase), 0);
        full_run("run2");

        // Randomized panel activity against the model
        for (int i = 0; i < 2500; i++) begin
            start = ($urandom_range(0, 7) == 0);
            pause = ($urandom_range(0, 9) == 0);
            abort = ($urandom_range(0, 59) == 0);
            door  = ($urandom_range(0, 15) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
